cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Round-robin arbiter for the common data bus (CDB) of the Tomasulo core. It arbitrates between functional-unit result sources: 3 adder slots, 3 multiplier slots and 1 load unit. Each cycle it grants at most one source and broadcasts that source's result and ROB tag on a registered CDB. The ROB and the reservation stations snoop the CDB. The ROB can stall new grants, and the pipeline can flush the arbiter.

Parameters:
NREQ, 7, number of result sources; index 0-2 adders, 3-5 multipliers, 6 load.
DATA_W, 32, result width.
TAG_W, 3, ROB tag width (8-entry ROB).
SRC_W, 3, width of source index; must satisfy 2^SRC_W >= NREQ.

Ports:
clk1  in  1  single clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  per-source result valid.
req_data  in  NREQ*DATA_W  packed results; source i occupies bits [i*DATA_W +: DATA_W].
req_tag  in  NREQ*TAG_W  packed ROB tags; source i occupies bits [i*TAG_W +: TAG_W].
req_ready  out  NREQ  combinational grant; a source transfers when valid & ready.
cdb_stall  in  1  ROB back-pressure; blocks new grants.
flush  in  1  synchronous pipeline flush.
cdb_valid  out  1  registered broadcast valid; high for one cycle per result.
cdb_data  out  DATA_W  broadcast result.
cdb_tag  out  TAG_W  broadcast ROB tag.
cdb_src  out  SRC_W  index of the broadcasting source.
bcast_cnt  out  16  count of broadcasts, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_src=0, bcast_cnt=0, round-robin pointer ptr=0. req_ready is 0 while rst_n=0.
- Handshake: a source asserts req_valid[i] with data and tag, and holds all three stable until the cycle where req_valid[i] & req_ready[i]. Dropping valid before acceptance is illegal.
- Grant logic (combinational):
  - Scan sources starting at ptr, ascending, wrapping from NREQ-1 to 0.
  - The first source with req_valid=1 is g.
  - req_ready is one-hot at g only when cdb_stall=0, flush=0 and rst_n=1. Otherwise req_ready=0.
  - No valid source gives req_ready=0.
- Transfer (posedge, ready[g] & valid[g]):
  - cdb_valid<=1, cdb_data<=req_data[g], cdb_tag<=req_tag[g], cdb_src<=g.
  - ptr<=(g+1) mod NREQ; g=NREQ-1 wraps to 0.
  - bcast_cnt<=bcast_cnt+1, saturating at 0xFFFF.
- Latency: accept in cycle N, CDB visible in cycle N+1.
- Broadcasts can be back-to-back, one per cycle.
- No transfer in a cycle: cdb_valid<=0. cdb_data, cdb_tag and cdb_src hold their last values. ptr is unchanged.
- cdb_stall=1: no grant. cdb_valid drops to 0 next cycle. ptr is held. A broadcast already registered is not retracted.
- flush=1 (priority over everything except reset): no grant. cdb_valid<=0 and ptr<=0; a broadcast registered in the previous cycle is killed the cycle flush is seen. bcast_cnt holds.
- flush and cdb_stall together: flush behaviour applies.
- Fairness: a continuously valid source waits at most NREQ-1 grants.
- Reset asserted mid-broadcast: outputs clear immediately (asynchronous). Pending requests are re-arbitrated from ptr=0 after release.

Test Plan:
- Reset: rst_n=0 with all req_valid=1 -> req_ready=0, cdb_valid=0, bcast_cnt=0. After release, first grant is src 0.
- Single source: req_valid[4]=1, data 0x0000_00AB, tag 5 -> req_ready=0x10 same cycle. Next cycle cdb_valid=1, cdb_data=0xAB, cdb_tag=5, cdb_src=4. Following cycle cdb_valid=0.
- Round-robin: all 7 sources valid continuously for 8 cycles -> grants in order 0,1,2,3,4,5,6,0. cdb_valid stays high from cycle 2. bcast_cnt=8 after drain.
- Stall: sources 1 and 6 valid, cdb_stall=1 for 3 cycles -> req_ready=0 and cdb_valid=0. On release, src 1 then src 6 broadcast on consecutive cycles.
- Flush: accept src 2 (ptr becomes 3), then flush=1 in the next cycle with src 5 valid -> no grant, cdb_valid=0 next cycle, ptr=0. With flush low, src 0 valid wins over src 5.
- Saturation: preload via 65 535 broadcasts, then 2 more -> bcast_cnt=0xFFFF.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: per-source result requests in, registered broadcast out.
// Latency: none; this is wiring only.
// Backpressure: req_ready is driven by the arbiter; a source holds until valid & ready.
interface cdb_arbiter_if #(
  parameter int NREQ   = 7,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int SRC_W  = 3
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_valid;
  logic [DATA_W-1:0]      cdb_data;
  logic [TAG_W-1:0]       cdb_tag;
  logic [SRC_W-1:0]       cdb_src;

  // Result producers and CDB snoopers
  modport master (
    output req_valid, req_data, req_tag,
    input  req_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_data, req_tag,
    output req_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one result source per cycle onto the registered CDB.
// Latency: accepted in cycle N, visible on the CDB in cycle N+1; back-to-back capable.
// Backpressure: cdb_stall or flush holds req_ready low; flush also kills cdb_valid and resets the pointer.
module cdb_arbiter #(
  parameter int NREQ   = 7,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int SRC_W  = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  cdb_arbiter_if.slave      bus,
  input  logic              cdb_stall,
  input  logic              flush,
  output logic [15:0]       bcast_cnt
);

  logic [SRC_W-1:0]  r_ptr;
  logic              r_cdb_vld;
  logic [DATA_W-1:0] r_cdb_dat;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [SRC_W-1:0]  r_cdb_src;
  logic [15:0]       r_bcast_cnt;

  logic              w_gnt_vld;
  logic [SRC_W-1:0]  w_gnt_idx;
  logic              w_xfer;
  logic [NREQ-1:0]   w_ready;
  logic [SRC_W-1:0]  w_ptr_nxt;

  // Find the first valid source scanning upward from r_ptr with wrap-around
  always_comb begin
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_gnt_vld && bus.req_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx[SRC_W-1:0];
      end
    end
  end

  // A grant is only offered while the bus is free to move; ready is therefore the transfer itself
  assign w_xfer    = w_gnt_vld & ~cdb_stall & ~flush & rst_n;
  assign w_ready   = w_xfer ? (NREQ'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt = (w_gnt_idx == SRC_W'(NREQ - 1)) ? '0 : w_gnt_idx + SRC_W'(1);

  // Register the winning result onto the CDB and advance the round-robin pointer
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_cdb_vld   <= 1'b0;
      r_cdb_dat   <= '0;
      r_cdb_tag   <= '0;
      r_cdb_src   <= '0;
      r_bcast_cnt <= '0;
    end else if (flush) begin
      r_cdb_vld <= 1'b0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      r_cdb_vld <= 1'b1;
      r_cdb_dat <= bus.req_data[w_gnt_idx*DATA_W +: DATA_W];
      r_cdb_tag <= bus.req_tag[w_gnt_idx*TAG_W +: TAG_W];
      r_cdb_src <= w_gnt_idx;
      r_ptr     <= w_ptr_nxt;
      if (r_bcast_cnt != 16'hFFFF) r_bcast_cnt <= r_bcast_cnt + 16'd1;
    end else begin
      r_cdb_vld <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.cdb_valid = r_cdb_vld;
  assign bus.cdb_data  = r_cdb_dat;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_src   = r_cdb_src;
  assign bcast_cnt     = r_bcast_cnt;

endmodule
